// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI responder: register map, status/control bit
// positions and framing FSM states.
package spi_slave_pkg;

  // Register addresses
  localparam logic [2:0] AddrRxData  = 3'd0;
  localparam logic [2:0] AddrTxData  = 3'd1;
  localparam logic [2:0] AddrStatus  = 3'd2;
  localparam logic [2:0] AddrControl = 3'd3;
  localparam logic [2:0] AddrEop     = 3'd6;

  // Status bit positions; control enables share the same positions
  localparam int unsigned BitTur  = 3;
  localparam int unsigned BitRoe  = 4;
  localparam int unsigned BitToe  = 5;
  localparam int unsigned BitTrdy = 6;
  localparam int unsigned BitRrdy = 7;
  localparam int unsigned BitE    = 8;
  localparam int unsigned BitEop  = 9;

  // Implemented status/control bits, without and with the EOP bit
  localparam logic [15:0] StatusMaskBase = 16'h01F8;
  localparam logic [15:0] StatusMaskEop  = 16'h03F8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-stage synchroniser for one asynchronous input, with rise/fall edge
// detection on the synchronised value. Stages must be at least 2.
module spi_slave_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  // Shift the input through the synchroniser chain and remember last output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder with a 16-bit CPU register port. SPI inputs are
// oversampled in the clk domain. Optional feature macro: SPI_SLAVE_EOP_EN
// (adds the EOP value register at address 6, status bit 9 and endofpacket).
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter logic [7:0]  IDLE_BYTE   = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
`ifdef SPI_SLAVE_EOP_EN
  ,
  output logic        endofpacket
`endif
);

  // Synchronised SPI inputs
  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_slave_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (SCLK),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_slave_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (SS_n),
    .q_o    (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_slave_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (MOSI),
    .q_o    (mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  // State
  state_e      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_hold_q, tx_hold_q;
  logic        primed_q;
  logic        tur_q, roe_q, toe_q, rrdy_q;
  logic [15:0] control_q;
  logic [15:0] readdata_q;
  logic        irq_q;
  logic        eop_bit;

  // CPU decode
  logic wr_en, rd_en, tx_wr, tx_accept, stat_wr, ctrl_wr, rx_rd;
  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign tx_wr     = wr_en & (address == AddrTxData);
  assign tx_accept = tx_wr & ~primed_q;
  assign stat_wr   = wr_en & (address == AddrStatus);
  assign ctrl_wr   = wr_en & (address == AddrControl);
  assign rx_rd     = rd_en & (address == AddrRxData);

  // Byte presented on a load: primed data, else the underrun filler
  logic [7:0] load_byte;
  assign load_byte = primed_q ? tx_hold_q : IDLE_BYTE;

  logic       load, complete;
  logic [7:0] rx_byte;
  assign rx_byte = {rx_shift_q[6:0], mosi_s};

  // Framing FSM: next state, shift registers and bit count
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    load       = 1'b0;
    complete   = 1'b0;
    if (ss_rise) begin
      // Abandon any partial byte; primed tx data stays primed
      state_d = StIdle;
      count_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_d = 3'd0;
          if (ss_fall) state_d = StLoad;
        end
        StLoad: begin
          load    = 1'b1;
          state_d = StShift;
        end
        StShift: begin
          if (sclk_rise) begin
            rx_shift_d = rx_byte;
            count_d    = count_q + 3'd1;
            complete   = (count_q == 3'd7);
          end else if (sclk_fall) begin
            // Count 0 here means a byte just finished: fetch the next one
            if (count_q == 3'd0) load = 1'b1;
            else                 tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
      if (load) tx_shift_d = load_byte;
    end
  end

  // Framing state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // During LOAD the shift register is not yet written, so present its source
  assign MISO    = (state_q == StLoad) ? load_byte[7] : tx_shift_q[7];
  assign MISO_oe = ~ss_s;

`ifdef SPI_SLAVE_EOP_EN
  logic [7:0] eop_val_q;
  logic       eop_q, eop_set;
  assign eop_set = (complete & (rx_byte == eop_val_q)) |
                   (tx_wr & (writedata[7:0] == eop_val_q));

  // EOP value register and sticky EOP flag (set wins over clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eop_val_q <= 8'h00;
      eop_q     <= 1'b0;
    end else begin
      if (wr_en && (address == AddrEop)) eop_val_q <= writedata[7:0];
      eop_q <= eop_set | (eop_q & ~stat_wr);
    end
  end

  assign eop_bit     = eop_q;
  assign endofpacket = eop_q;
  localparam logic [15:0] CtrlMask = StatusMaskEop;
`else
  assign eop_bit = 1'b0;
  localparam logic [15:0] CtrlMask = StatusMaskBase;
`endif

  // Data holding registers and status flags; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_hold_q <= 8'h00;
      tx_hold_q <= 8'h00;
      primed_q  <= 1'b0;
      tur_q     <= 1'b0;
      roe_q     <= 1'b0;
      toe_q     <= 1'b0;
      rrdy_q    <= 1'b0;
      control_q <= 16'h0000;
    end else begin
      if (complete)  rx_hold_q <= rx_byte;
      if (tx_accept) tx_hold_q <= writedata[7:0];
      if (ctrl_wr)   control_q <= writedata & CtrlMask;
      primed_q <= tx_accept | (primed_q & ~(load & primed_q));
      tur_q    <= (load & ~primed_q) | (tur_q & ~stat_wr);
      roe_q    <= (complete & rrdy_q) | (roe_q & ~stat_wr);
      toe_q    <= (tx_wr & primed_q) | (toe_q & ~stat_wr);
      rrdy_q   <= complete | (rrdy_q & ~rx_rd);
    end
  end

  // Status word assembly
  logic [15:0] status;
  always_comb begin
    status          = 16'h0000;
    status[BitTur]  = tur_q;
    status[BitRoe]  = roe_q;
    status[BitToe]  = toe_q;
    status[BitTrdy] = ~primed_q;
    status[BitRrdy] = rrdy_q;
    status[BitE]    = tur_q | roe_q | toe_q;
    status[BitEop]  = eop_bit;
  end

  // Read mux
  logic [15:0] rd_mux;
  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      AddrRxData:  rd_mux = {8'h00, rx_hold_q};
      AddrStatus:  rd_mux = status;
      AddrControl: rd_mux = control_q;
`ifdef SPI_SLAVE_EOP_EN
      AddrEop:     rd_mux = {8'h00, eop_val_q};
`endif
      default:     rd_mux = 16'h0000;
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= 16'h0000;
      irq_q      <= 1'b0;
    end else begin
      if (rd_en) readdata_q <= rd_mux;
      irq_q <= |(status & control_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: drives an SPI mode-0 master and the CPU
// port, compares against hand-computed values.
module tb_spi_slave_port;

  localparam time HALF = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        MISO_oe;
`ifdef SPI_SLAVE_EOP_EN
  logic        endofpacket;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  spi_slave_port dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .SCLK       (SCLK),
    .SS_n       (SS_n),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .MISO_oe    (MISO_oe)
`ifdef SPI_SLAVE_EOP_EN
    ,
    .endofpacket(endofpacket)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    SS_n = 1'b0;
    #HALF;
  endtask

  task automatic ss_end();
    #HALF;
    SS_n = 1'b1;
    #(4 * HALF);
  endtask

  // Master side: MOSI set while SCLK low, MISO sampled at the rising edge
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      #HALF;
      SCLK = 1'b1;
      rx = {rx[6:0], MISO};
      #HALF;
      SCLK = 1'b0;
    end
  endtask

  logic [15:0] rd;
  logic [7:0]  mrx, mrx2;

  initial begin
    // Reset state
    #23;
    check_eq("rst_readdata", readdata, 16'h0000);
    check_eq("rst_irq", 16'(irq), 16'h0000);
    check_eq("rst_miso", 16'(MISO), 16'h0000);
    check_eq("rst_miso_oe", 16'(MISO_oe), 16'h0000);
    reset_n = 1'b1;
    cpu_read(AddrStatusTb(), rd);
    check_eq("rst_status", rd, 16'h0040);
    cpu_read(3'd3, rd);
    check_eq("rst_control", rd, 16'h0000);

    // Primed A5, master sends 3C
    cpu_write(3'd1, 16'h00A5);
    cpu_read(3'd2, rd);
    check_eq("primed_status", rd, 16'h0000);
    ss_begin();
    check_eq("frame_miso_oe", 16'(MISO_oe), 16'h0001);
    spi_bits(8'h3C, 8, mrx);
    ss_end();
    check_eq("a5_master_rx", 16'(mrx), 16'h00A5);
    check_eq("post_miso_oe", 16'(MISO_oe), 16'h0000);
    cpu_read(3'd2, rd);
    check_eq("a5_status", rd, 16'h01C8);
    cpu_read(3'd0, rd);
    check_eq("rx_3c", rd, 16'h003C);
    cpu_read(3'd2, rd);
    check_eq("rrdy_cleared", rd, 16'h0148);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd);
    check_eq("status_cleared", rd, 16'h0040);

    // Underrun with TUR interrupt enabled
    cpu_write(3'd3, 16'h0008);
    idle(2);
    check_eq("tur_irq_low", 16'(irq), 16'h0000);
    ss_begin();
    spi_bits(8'h55, 8, mrx);
    ss_end();
    check_eq("underrun_rx", 16'(mrx), 16'h0000);
    check_eq("tur_irq_high", 16'(irq), 16'h0001);
    cpu_read(3'd0, rd);
    check_eq("rx_55", rd, 16'h0055);
    cpu_write(3'd2, 16'h0000);
    idle(2);
    check_eq("tur_irq_clr", 16'(irq), 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Two bytes in one frame, no read between: overrun, newest wins
    ss_begin();
    spi_bits(8'h11, 8, mrx);
    spi_bits(8'h22, 8, mrx2);
    ss_end();
    cpu_read(3'd2, rd);
    check_eq("overrun_status", rd, 16'h01D8);
    cpu_read(3'd0, rd);
    check_eq("rx_22", rd, 16'h0022);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd);
    check_eq("roe_tur_cleared", rd, 16'h0040);

    // Two tx writes before a frame: TOE, first value sent
    cpu_write(3'd1, 16'h0096);
    cpu_write(3'd1, 16'h0069);
    cpu_read(3'd2, rd);
    check_eq("toe_status", rd, 16'h0120);
    ss_begin();
    spi_bits(8'hC3, 8, mrx);
    ss_end();
    check_eq("toe_master_rx", 16'(mrx), 16'h0096);
    cpu_read(3'd2, rd);
    check_eq("toe_post_status", rd, 16'h01E8);
    cpu_read(3'd0, rd);
    check_eq("rx_c3", rd, 16'h00C3);
    cpu_write(3'd2, 16'h0000);

    // Partial byte discarded, then a full byte
    ss_begin();
    spi_bits(8'hF0, 4, mrx);
    ss_end();
    cpu_read(3'd2, rd);
    check_eq("partial_status", rd, 16'h0148);
    ss_begin();
    spi_bits(8'h7E, 8, mrx);
    ss_end();
    cpu_read(3'd2, rd);
    check_eq("after_partial_status", rd, 16'h01C8);
    cpu_read(3'd0, rd);
    check_eq("rx_7e", rd, 16'h007E);
    cpu_write(3'd2, 16'h0000);

    // Unmapped addresses and control mask
    cpu_write(3'd7, 16'hFFFF);
    cpu_read(3'd7, rd);
    check_eq("addr7_zero", rd, 16'h0000);
    cpu_read(3'd5, rd);
    check_eq("addr5_zero", rd, 16'h0000);
    cpu_write(3'd3, 16'hFFFF);
    cpu_read(3'd3, rd);
`ifdef SPI_SLAVE_EOP_EN
    check_eq("control_mask", rd, 16'h03F8);
`else
    check_eq("control_mask", rd, 16'h01F8);
`endif
    idle(2);
    check_eq("trdy_irq", 16'(irq), 16'h0001);
    cpu_write(3'd3, 16'h0000);

`ifdef SPI_SLAVE_EOP_EN
    cpu_write(3'd6, 16'h000D);
    cpu_read(3'd6, rd);
    check_eq("eop_value", rd, 16'h000D);
    cpu_write(3'd3, 16'h0200);
    ss_begin();
    spi_bits(8'h0D, 8, mrx);
    ss_end();
    check_eq("endofpacket", 16'(endofpacket), 16'h0001);
    check_eq("eop_irq", 16'(irq), 16'h0001);
    cpu_read(3'd0, rd);
    check_eq("rx_0d", rd, 16'h000D);
    cpu_write(3'd2, 16'h0000);
    idle(1);
    check_eq("eop_cleared", 16'(endofpacket), 16'h0000);
    cpu_write(3'd3, 16'h0000);
`else
    cpu_write(3'd6, 16'h000D);
    cpu_read(3'd6, rd);
    check_eq("addr6_zero", rd, 16'h0000);
`endif

    // Reset asserted mid-frame
    cpu_write(3'd3, 16'h0040);
    idle(2);
    ss_begin();
    spi_bits(8'hAA, 3, mrx);
    reset_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b0;
    #20;
    check_eq("midrst_miso_oe", 16'(MISO_oe), 16'h0000);
    check_eq("midrst_irq", 16'(irq), 16'h0000);
    reset_n = 1'b1;
    cpu_read(3'd3, rd);
    check_eq("midrst_control", rd, 16'h0000);
    cpu_read(3'd2, rd);
    check_eq("midrst_status", rd, 16'h0040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [2:0] AddrStatusTb();
    return 3'd2;
  endfunction

endmodule
